// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// feeds the IF/ID pipeline register that drives the main decoder.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [5:0]  ifid_opcode,
    output logic [31:0] ifid_pc4,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] pc_plus4;
    logic        ifid_valid_next;
    logic [31:0] ifid_instr_next, ifid_pc4_next;
    logic [31:0] fetch_count_next;
    logic [31:0] hold_instr, hold_instr_next;
    logic [31:0] hold_pc4, hold_pc4_next;
    logic        redirect;
    logic [31:0] redirect_target;

    assign pc_plus4    = pc + 32'd4;
    assign imem_addr   = pc;
    assign ifid_opcode = ifid_instr[31:26];

    // The jump being resolved sits in IF/ID, so its region bits come from ifid_pc4.
    assign redirect        = (state != S_BOOT) && (branch_taken || jmp);
    assign redirect_target = branch_taken ? branch_target
                                          : {ifid_pc4[31:28], jmp_index, 2'b00};

    // NOTE: every next-state variable gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        ifid_valid_next  = ifid_valid;
        ifid_instr_next  = ifid_instr;
        ifid_pc4_next    = ifid_pc4;
        fetch_count_next = fetch_count;
        hold_instr_next  = hold_instr;
        hold_pc4_next    = hold_pc4;
        imem_req         = 1'b0;

        case (state)
            S_BOOT: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack && !stall) begin
                    ifid_valid_next  = 1'b1;
                    ifid_instr_next  = imem_rdata;
                    ifid_pc4_next    = pc_plus4;
                    pc_next          = pc_plus4;
                    fetch_count_next = fetch_count + 32'd1;
                end else if (imem_ack && stall) begin
                    // Word arrived while decode is blocked: park it until the stall clears.
                    hold_instr_next = imem_rdata;
                    hold_pc4_next   = pc_plus4;
                    state_next      = S_HOLD;
                end else if (!imem_ack && !stall) begin
                    ifid_valid_next = 1'b0;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    ifid_valid_next  = 1'b1;
                    ifid_instr_next  = hold_instr;
                    ifid_pc4_next    = hold_pc4;
                    pc_next          = pc_plus4;
                    fetch_count_next = fetch_count + 32'd1;
                    state_next       = S_FETCH;
                end
            end
            default: begin
                state_next = S_BOOT;
            end
        endcase

        // Redirect overrides stall and any same-cycle ack; a parked word is dropped.
        if (redirect) begin
            pc_next          = redirect_target & ~32'h3;
            ifid_valid_next  = 1'b0;
            ifid_instr_next  = ifid_instr;
            ifid_pc4_next    = ifid_pc4;
            fetch_count_next = fetch_count;
            hold_instr_next  = hold_instr;
            hold_pc4_next    = hold_pc4;
            state_next       = S_FETCH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BOOT;
            pc          <= RESET_PC;
            ifid_valid  <= 1'b0;
            ifid_instr  <= 32'h0;
            ifid_pc4    <= 32'h0;
            fetch_count <= 32'h0;
            hold_instr  <= 32'h0;
            hold_pc4    <= 32'h0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            ifid_valid  <= ifid_valid_next;
            ifid_instr  <= ifid_instr_next;
            ifid_pc4    <= ifid_pc4_next;
            fetch_count <= fetch_count_next;
            hold_instr  <= hold_instr_next;
            hold_pc4    <= hold_pc4_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/hold, redirects,
// priority, mid-run reset and PC wraparound, all against hand-computed values.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    logic        imem_ack;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jmp;
    logic [25:0] jmp_index;
    logic [31:0] rdata_xor;

    logic        imem_req, imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        ifid_valid, ifid_valid2;
    logic [31:0] ifid_instr, ifid_instr2;
    logic [5:0]  ifid_opcode, ifid_opcode2;
    logic [31:0] ifid_pc4, ifid_pc42;
    logic [31:0] fetch_count, fetch_count2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Memory model: each word holds its own address, optionally scrambled.
    assign imem_rdata  = imem_addr ^ rdata_xor;
    assign imem_rdata2 = imem_addr2;

    fetch_stage u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jmp(jmp), .jmp_index(jmp_index),
        .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_opcode(ifid_opcode),
        .ifid_pc4(ifid_pc4), .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset(reset2),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata2),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(32'h0),
        .jmp(1'b0), .jmp_index(26'h0),
        .ifid_valid(ifid_valid2), .ifid_instr(ifid_instr2), .ifid_opcode(ifid_opcode2),
        .ifid_pc4(ifid_pc42), .fetch_count(fetch_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1;
        imem_ack = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jmp = 1'b0; jmp_index = 26'h0; rdata_xor = 32'h0;
        step(); step();

        check("rst_req",   32'(imem_req),   32'h0);
        check("rst_addr",  imem_addr,       32'h0);
        check("rst_valid", 32'(ifid_valid), 32'h0);
        check("rst_instr", ifid_instr,      32'h0);
        check("rst_pc4",   ifid_pc4,        32'h0);
        check("rst_count", fetch_count,     32'h0);

        // Sequential fetch with ack tied high
        reset = 1'b0; imem_ack = 1'b1;
        step();
        check("boot_req",   32'(imem_req),   32'h1);
        check("boot_valid", 32'(ifid_valid), 32'h0);
        step();
        check("f0_instr", ifid_instr,      32'h0);
        check("f0_valid", 32'(ifid_valid), 32'h1);
        check("f0_pc4",   ifid_pc4,        32'h4);
        step();
        check("f1_instr", ifid_instr, 32'h4);
        step();
        check("f2_instr", ifid_instr,  32'h8);
        check("f2_count", fetch_count, 32'd3);
        check("f2_addr",  imem_addr,   32'hC);

        // Stall for three cycles while the word at 0xC is acked
        stall = 1'b1;
        step();
        check("hold_req",   32'(imem_req), 32'h0);
        check("hold_instr", ifid_instr,    32'h8);
        check("hold_addr",  imem_addr,     32'hC);
        rdata_xor = 32'hA500_0000;
        step();
        check("hold_valid", 32'(ifid_valid), 32'h1);
        check("hold_count", fetch_count,     32'd3);
        step();
        check("hold_req2", 32'(imem_req), 32'h0);
        stall = 1'b0;
        step();
        check("rel_instr", ifid_instr,    32'hC);
        check("rel_pc4",   ifid_pc4,      32'h10);
        check("rel_addr",  imem_addr,     32'h10);
        check("rel_count", fetch_count,   32'd4);
        check("rel_req",   32'(imem_req), 32'h1);
        rdata_xor = 32'h0;

        // Branch in the same cycle as an ack; unaligned target bits are dropped
        branch_taken = 1'b1; branch_target = 32'h41;
        step();
        check("br_addr",  imem_addr,       32'h40);
        check("br_valid", 32'(ifid_valid), 32'h0);
        check("br_instr", ifid_instr,      32'hC);
        check("br_count", fetch_count,     32'd4);
        branch_taken = 1'b0;
        step();
        check("br_fetch", ifid_instr,  32'h40);
        check("br_pc4",   ifid_pc4,    32'h44);
        check("br_cnt2",  fetch_count, 32'd5);

        // Missing ack gives a bubble without clearing the instruction
        imem_ack = 1'b0;
        step();
        check("bub_valid", 32'(ifid_valid), 32'h0);
        check("bub_instr", ifid_instr,      32'h40);
        check("bub_addr",  imem_addr,       32'h44);
        imem_ack = 1'b1;
        step();
        check("bub_next", ifid_instr,  32'h44);
        check("bub_cnt",  fetch_count, 32'd6);

        // Jump resolved against ifid_pc4 = 0x1000_0008
        branch_taken = 1'b1; branch_target = 32'h1000_0004;
        step();
        branch_taken = 1'b0;
        step();
        check("jp_pc4", ifid_pc4, 32'h1000_0008);
        jmp = 1'b1; jmp_index = 26'h10;
        step();
        check("jmp_addr",  imem_addr,       32'h1000_0040);
        check("jmp_valid", 32'(ifid_valid), 32'h0);
        check("jmp_count", fetch_count,     32'd7);

        // Branch, jump and stall together: branch wins, stall ignored
        branch_taken = 1'b1; branch_target = 32'h200;
        jmp_index = 26'h3FF_FFFF; stall = 1'b1;
        step();
        check("pri_addr", imem_addr,     32'h200);
        check("pri_req",  32'(imem_req), 32'h1);
        branch_taken = 1'b0; jmp = 1'b0; stall = 1'b0;
        step();
        check("pri_instr", ifid_instr,  32'h200);
        check("pri_count", fetch_count, 32'd8);

        // Jump from S_HOLD discards the parked word (ifid_pc4 = 0x204)
        stall = 1'b1;
        step();
        check("hj_req", 32'(imem_req), 32'h0);
        jmp = 1'b1; jmp_index = 26'h3;
        step();
        check("hj_addr", imem_addr,     32'hC);
        check("hj_req2", 32'(imem_req), 32'h1);
        jmp = 1'b0; stall = 1'b0;
        step();
        check("hj_instr", ifid_instr,  32'hC);
        check("hj_opc",   32'(ifid_opcode), 32'h0);
        check("hj_count", fetch_count, 32'd9);

        // Opcode field tracks instr[31:26]
        rdata_xor = 32'hFC00_0000;
        step();
        check("opc", 32'(ifid_opcode), 32'h3F);
        rdata_xor = 32'h0;

        // Reset mid-run with an ack pending
        reset = 1'b1;
        step();
        check("mr_count", fetch_count,     32'h0);
        check("mr_valid", 32'(ifid_valid), 32'h0);
        check("mr_instr", ifid_instr,      32'h0);
        check("mr_req",   32'(imem_req),   32'h0);
        check("mr_addr",  imem_addr,       32'h0);

        // PC wraparound from RESET_PC = 0xFFFF_FFFC
        check("wr_rst", imem_addr2, 32'hFFFF_FFFC);
        reset2 = 1'b0;
        step();
        check("wr_addr0", imem_addr2,     32'hFFFF_FFFC);
        check("wr_req",   32'(imem_req2), 32'h1);
        step();
        check("wr_addr1", imem_addr2,  32'h0);
        check("wr_pc4",   ifid_pc42,   32'h0);
        check("wr_instr", ifid_instr2, 32'hFFFF_FFFC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
